// File: rtl/load_writeback_if.sv
// load_writeback_if: retire-side handshake from execute plus the data-memory
// read response consumed by the writeback stage.
//   wb_valid/wb_ready   : instruction handshake (execute -> writeback)
//   wb_rd_num/wb_result : destination register, ALU result or load byte address
//   wb_is_load/wb_funct3/wb_halt : instruction kind and load width/sign code
//   mem_rdata/mem_rvalid: aligned memory word and single-cycle response strobe
interface load_writeback_if #(
  parameter int unsigned XLEN = 32
);
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd_num;
  logic [XLEN-1:0] wb_result;
  logic            wb_is_load;
  logic [2:0]      wb_funct3;
  logic            wb_halt;
  logic [31:0]     mem_rdata;
  logic            mem_rvalid;

  // Execute stage and memory side.
  modport master (
    output wb_valid, wb_rd_num, wb_result, wb_is_load, wb_funct3, wb_halt,
    output mem_rdata, mem_rvalid,
    input  wb_ready
  );

  // Writeback stage side.
  modport slave (
    input  wb_valid, wb_rd_num, wb_result, wb_is_load, wb_funct3, wb_halt,
    input  mem_rdata, mem_rvalid,
    output wb_ready
  );
endinterface

// File: rtl/load_writeback.sv
// load_writeback: final pipeline stage driving the register file write port.
// ALU results retire one cycle after accept; loads wait in LOAD_WAIT for the
// memory response, then are byte/halfword extracted and sign/zero extended.
// A retiring halt raises a sticky halted flag and parks the stage.
//   clk, rst_b : clock, asynchronous active-low reset
//   bus        : load_writeback_if.slave (upstream handshake + memory response)
//   rd_num/rd_data/rd_we : registered regfile write port
//   load_err   : one-cycle pulse for an illegal or misaligned load
//   halted     : sticky halt flag
//   retired    : count of completed instructions (wraps)
module load_writeback #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  load_writeback_if.slave   bus,
  output logic [4:0]        rd_num,
  output logic [XLEN-1:0]   rd_data,
  output logic              rd_we,
  output logic              load_err,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    HALTED    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [REG_W-1:0]  ld_rd_q, ld_rd_d;
  logic [F3_W-1:0]   ld_f3_q, ld_f3_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic [REG_W-1:0]  rd_num_q, rd_num_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic              rd_we_q, rd_we_d;
  logic              load_err_q, load_err_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [7:0]        ld_byte_c;
  logic [15:0]       ld_half_c;
  logic [XLEN-1:0]   ld_data_c;
  logic              ld_err_c;

  assign bus.wb_ready = (state_q == IDLE);

  // Load data extraction and legality check from the captured funct3/offset.
  always_comb begin
    ld_byte_c = 8'h00;
    ld_half_c = ld_off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ld_data_c = '0;
    ld_err_c  = 1'b0;
    case (ld_off_q)
      2'd0:    ld_byte_c = bus.mem_rdata[7:0];
      2'd1:    ld_byte_c = bus.mem_rdata[15:8];
      2'd2:    ld_byte_c = bus.mem_rdata[23:16];
      default: ld_byte_c = bus.mem_rdata[31:24];
    endcase
    case (ld_f3_q)
      3'b000: ld_data_c = {{(XLEN-8){ld_byte_c[7]}}, ld_byte_c};
      3'b100: ld_data_c = {{(XLEN-8){1'b0}}, ld_byte_c};
      3'b001: begin
        ld_data_c = {{(XLEN-16){ld_half_c[15]}}, ld_half_c};
        ld_err_c  = ld_off_q[0];
      end
      3'b101: begin
        ld_data_c = {{(XLEN-16){1'b0}}, ld_half_c};
        ld_err_c  = ld_off_q[0];
      end
      3'b010: begin
        ld_data_c = XLEN'(bus.mem_rdata);
        ld_err_c  = (ld_off_q != 2'd0);
      end
      default: ld_err_c = 1'b1;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    rd_num_d   = rd_num_q;
    rd_data_d  = rd_data_q;
    rd_we_d    = 1'b0;
    load_err_d = 1'b0;
    halted_d   = halted_q;
    retired_d  = retired_q;
    case (state_q)
      IDLE: begin
        if (bus.wb_valid) begin
          if (bus.wb_halt) begin
            halted_d  = 1'b1;
            retired_d = retired_q + CNT_W'(1);
            state_d   = HALTED;
          end else if (bus.wb_is_load) begin
            ld_rd_d  = bus.wb_rd_num;
            ld_f3_d  = bus.wb_funct3;
            ld_off_d = bus.wb_result[1:0];
            state_d  = LOAD_WAIT;
          end else begin
            // x0 writes are dropped but still count as retired.
            rd_we_d   = (bus.wb_rd_num != '0);
            rd_num_d  = bus.wb_rd_num;
            rd_data_d = bus.wb_result;
            retired_d = retired_q + CNT_W'(1);
          end
        end
      end
      LOAD_WAIT: begin
        if (bus.mem_rvalid) begin
          rd_num_d  = ld_rd_q;
          retired_d = retired_q + CNT_W'(1);
          state_d   = IDLE;
          if (ld_err_c) begin
            load_err_d = 1'b1;
          end else begin
            rd_we_d   = (ld_rd_q != '0);
            rd_data_d = ld_data_c;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_off_q   <= '0;
      rd_num_q   <= '0;
      rd_data_q  <= '0;
      rd_we_q    <= 1'b0;
      load_err_q <= 1'b0;
      halted_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
      rd_num_q   <= rd_num_d;
      rd_data_q  <= rd_data_d;
      rd_we_q    <= rd_we_d;
      load_err_q <= load_err_d;
      halted_q   <= halted_d;
      retired_q  <= retired_d;
    end
  end

  assign rd_num   = rd_num_q;
  assign rd_data  = rd_data_q;
  assign rd_we    = rd_we_q;
  assign load_err = load_err_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_load_writeback.sv
// tb_load_writeback: table-driven vectors through a retire scoreboard, plus
// hand sequences for halt and reset-during-load.
module tb_load_writeback;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam int unsigned NVEC = 18;

  logic        clk;
  logic        rst_b;
  logic [4:0]  rd_num;
  logic [31:0] rd_data;
  logic        rd_we;
  logic        load_err;
  logic        halted;
  logic [31:0] retired;

  load_writeback_if #(.XLEN(32)) bus ();

  load_writeback #(.XLEN(32), .CNT_W(32)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .bus      (bus),
    .rd_num   (rd_num),
    .rd_data  (rd_data),
    .rd_we    (rd_we),
    .load_err (load_err),
    .halted   (halted),
    .retired  (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          is_load;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          delay;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        we;
    logic        err;
    logic [4:0]  num;
    logic [31:0] data;
    logic [31:0] ret;
  } exp_t;

  vec_t        vecs [NVEC];
  exp_t        sb_q [$];
  int          checks;
  int          failures;
  logic [31:0] exp_ret;
  logic [31:0] prev_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Observe outputs on the falling edge; every retire pops one expectation.
  task automatic mon();
    exp_t e;
    if (!rst_b) begin
      prev_ret = retired;
    end else begin
      if (retired !== prev_ret) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_retire actual=%0d expected=%0d", retired, prev_ret);
        end else begin
          e = sb_q.pop_front();
          chk("retire_rd_we", 32'(rd_we), 32'(e.we));
          chk("retire_load_err", 32'(load_err), 32'(e.err));
          chk("retire_count", retired, e.ret);
          if (e.we) begin
            chk("retire_rd_num", 32'(rd_num), 32'(e.num));
            chk("retire_rd_data", rd_data, e.data);
          end
        end
      end else begin
        checks++;
        if (rd_we !== 1'b0 || load_err !== 1'b0) begin
          failures++;
          $display("FAIL spurious_write actual=we%0b/err%0b expected=we0/err0", rd_we, load_err);
        end
      end
      prev_ret = retired;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic err, input logic [4:0] num,
                      input logic [31:0] data);
    exp_t e;
    exp_ret = exp_ret + 32'd1;
    e.we = we; e.err = err; e.num = num; e.data = data; e.ret = exp_ret;
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.wb_valid   = 1'b0;
    bus.wb_rd_num  = '0;
    bus.wb_result  = '0;
    bus.wb_is_load = 1'b0;
    bus.wb_funct3  = '0;
    bus.wb_halt    = 1'b0;
    bus.mem_rdata  = JUNK;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic issue_alu(input logic [4:0] rd, input logic [31:0] val, input logic exp_we);
    bus.wb_valid   = 1'b1;
    bus.wb_is_load = 1'b0;
    bus.wb_halt    = 1'b0;
    bus.wb_rd_num  = rd;
    bus.wb_result  = val;
    chk("ready_alu", 32'(bus.wb_ready), 32'd1);
    push(exp_we, 1'b0, rd, val);
    tick();
    bus.wb_valid = 1'b0;
  endtask

  task automatic issue_load(input vec_t v);
    bus.wb_valid   = 1'b1;
    bus.wb_is_load = 1'b1;
    bus.wb_halt    = 1'b0;
    bus.wb_rd_num  = v.rd;
    bus.wb_funct3  = v.f3;
    bus.wb_result  = v.addr;
    // A response in the accept cycle must be ignored.
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = JUNK;
    chk("ready_load", 32'(bus.wb_ready), 32'd1);
    push(v.exp_we, v.exp_err, v.rd, v.exp_data);
    tick();
    bus.wb_valid   = 1'b0;
    bus.wb_is_load = 1'b0;
    bus.mem_rvalid = 1'b0;
    chk("ready_load_wait", 32'(bus.wb_ready), 32'd0);
    for (int d = 1; d < v.delay; d++) begin
      tick();
      chk("ready_load_wait", 32'(bus.wb_ready), 32'd0);
    end
    bus.mem_rdata  = v.rdata;
    bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = JUNK;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", sb_q.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_ret  = '0;
    prev_ret = '0;
    rst_b    = 1'b0;
    idle_inputs();

    //            load  rd     f3      addr          rdata         dly we    data          err
    vecs[0]  = '{1'b0, 5'd5,  3'b000, 32'h0000_1234, 32'h0,        1, 1'b1, 32'h0000_1234, 1'b0};
    vecs[1]  = '{1'b1, 5'd6,  3'b000, 32'h0000_0102, 32'h0080_FF00, 3, 1'b1, 32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{1'b1, 5'd7,  3'b101, 32'h0000_0002, 32'h8001_C0DE, 1, 1'b1, 32'h0000_8001, 1'b0};
    vecs[3]  = '{1'b1, 5'd8,  3'b001, 32'h0000_0000, 32'h8001_C0DE, 2, 1'b1, 32'hFFFF_C0DE, 1'b0};
    vecs[4]  = '{1'b1, 5'd9,  3'b010, 32'h0000_0000, 32'h8001_C0DE, 1, 1'b1, 32'h8001_C0DE, 1'b0};
    vecs[5]  = '{1'b1, 5'd10, 3'b100, 32'h0000_0000, 32'h8001_C0DE, 4, 1'b1, 32'h0000_00DE, 1'b0};
    vecs[6]  = '{1'b1, 5'd11, 3'b010, 32'h0000_0001, 32'h8001_C0DE, 1, 1'b0, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 5'd0,  3'b000, 32'h0000_AAAA, 32'h0,        1, 1'b0, 32'h0000_AAAA, 1'b0};
    vecs[8]  = '{1'b1, 5'd12, 3'b000, 32'h0000_0003, 32'h7F12_3456, 2, 1'b1, 32'h0000_007F, 1'b0};
    vecs[9]  = '{1'b1, 5'd13, 3'b101, 32'h0000_0003, 32'h8001_C0DE, 1, 1'b0, 32'h0,        1'b1};
    vecs[10] = '{1'b1, 5'd14, 3'b011, 32'h0000_0000, 32'h8001_C0DE, 1, 1'b0, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 5'd15, 3'b110, 32'h0000_0000, 32'h8001_C0DE, 2, 1'b0, 32'h0,        1'b1};
    vecs[12] = '{1'b1, 5'd16, 3'b111, 32'h0000_0000, 32'h8001_C0DE, 1, 1'b0, 32'h0,        1'b1};
    vecs[13] = '{1'b1, 5'd17, 3'b000, 32'h0000_0001, 32'h0000_A500, 1, 1'b1, 32'hFFFF_FFA5, 1'b0};
    vecs[14] = '{1'b1, 5'd18, 3'b001, 32'h0000_0002, 32'h7FFF_0000, 3, 1'b1, 32'h0000_7FFF, 1'b0};
    vecs[15] = '{1'b0, 5'd31, 3'b000, 32'hFFFF_FFFF, 32'h0,        1, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[16] = '{1'b1, 5'd0,  3'b010, 32'h0000_0000, 32'h1234_5678, 1, 1'b0, 32'h0,        1'b0};
    vecs[17] = '{1'b1, 5'd19, 3'b100, 32'h0000_0003, 32'h8001_C0DE, 1, 1'b1, 32'h0000_0080, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_we", 32'(rd_we), 32'd0);
    chk("reset_rd_num", 32'(rd_num), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_load_err", 32'(load_err), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_retired", retired, 32'd0);
    rst_b = 1'b1;
    #1;
    chk("reset_ready", 32'(bus.wb_ready), 32'd1);
    tick();

    // Vector table, with back-to-back ALU accepts at the end.
    for (int i = 0; i < int'(NVEC); i++) begin
      if (vecs[i].is_load) issue_load(vecs[i]);
      else issue_alu(vecs[i].rd, vecs[i].addr, vecs[i].exp_we);
    end
    issue_alu(5'd20, 32'h0000_0001, 1'b1);
    issue_alu(5'd21, 32'h0000_0002, 1'b1);
    issue_alu(5'd22, 32'h8000_0000, 1'b1);
    drain();

    // Halt after three ALU instructions; halt outranks is_load.
    rst_b = 1'b0;
    #1;
    sb_q.delete();
    exp_ret = '0;
    tick();
    rst_b = 1'b1;
    tick();
    issue_alu(5'd1, 32'h11, 1'b1);
    issue_alu(5'd2, 32'h22, 1'b1);
    issue_alu(5'd3, 32'h33, 1'b1);
    bus.wb_valid   = 1'b1;
    bus.wb_halt    = 1'b1;
    bus.wb_is_load = 1'b1;
    bus.wb_funct3  = 3'b010;
    bus.wb_rd_num  = 5'd4;
    bus.wb_result  = 32'h0;
    push(1'b0, 1'b0, 5'd4, 32'h0);
    tick();
    idle_inputs();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_ready", 32'(bus.wb_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus.wb_valid   = 1'b1;
      bus.wb_rd_num  = 5'd7;
      bus.wb_result  = 32'h5555_5555;
      bus.mem_rvalid = 1'b1;
      tick();
      chk("halt_sticky", 32'(halted), 32'd1);
      chk("halt_ready_low", 32'(bus.wb_ready), 32'd0);
      chk("halt_retired", retired, 32'd4);
    end
    idle_inputs();
    drain();

    // Reset while a load is pending: no write after release.
    rst_b = 1'b0;
    #1;
    sb_q.delete();
    exp_ret = '0;
    tick();
    rst_b = 1'b1;
    tick();
    bus.wb_valid   = 1'b1;
    bus.wb_is_load = 1'b1;
    bus.wb_funct3  = 3'b010;
    bus.wb_rd_num  = 5'd9;
    bus.wb_result  = 32'h0;
    tick();
    idle_inputs();
    chk("rstload_wait_ready", 32'(bus.wb_ready), 32'd0);
    tick();
    rst_b = 1'b0;
    #1;
    chk("rstload_rd_we", 32'(rd_we), 32'd0);
    chk("rstload_retired_in_reset", retired, 32'd0);
    chk("rstload_ready_in_reset", 32'(bus.wb_ready), 32'd1);
    tick();
    rst_b = 1'b1;
    bus.mem_rdata  = 32'h1111_1111;
    bus.mem_rvalid = 1'b1;
    tick();
    idle_inputs();
    chk("rstload_ready", 32'(bus.wb_ready), 32'd1);
    repeat (3) tick();
    chk("rstload_retired", retired, 32'd0);
    chk("rstload_halted", 32'(halted), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
